// File: rtl/hood_mode_fsm.sv
// Range-hood mode controller: N fan levels, timed boost, self-clean and power-off run-on.
// Optional HOOD_GESTURE_EN adds gest_l/gest_r swipe power toggling and gest_pending.
module hood_mode_fsm #(
  parameter int LEVELS        = 3,
  parameter int BOOST_SEC     = 60,
  parameter int CLEAN_SEC     = 180,
  parameter int OFF_DELAY_SEC = 10,
  parameter int CNT_W         = 8,
  parameter int LVL_W         = $clog2(LEVELS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_1hz,
  input  logic             power_pulse,
  input  logic             level_req,
  input  logic [LVL_W-1:0] level_sel,
  input  logic             boost_req,
  input  logic             clean_req,
`ifdef HOOD_GESTURE_EN
  input  logic             gest_l,
  input  logic             gest_r,
  output logic             gest_pending,
`endif
  output logic [LVL_W-1:0] fan_level,
  output logic [2:0]       state_code,
  output logic [CNT_W-1:0] countdown,
  output logic             powered,
  output logic             boost_used,
  output logic             clean_done
);

  // state    | meaning
  // OFF      | unpowered, only a power request is honoured
  // STANDBY  | powered, fan stopped
  // RUN      | fan at latched normal level
  // BOOST    | fan at top level for BOOST_SEC ticks, once per session
  // CLEAN    | self-clean for CLEAN_SEC ticks, fan stopped
  // COOLDOWN | fan at level 1 for OFF_DELAY_SEC ticks, then OFF
  localparam logic [2:0] S_OFF      = 3'd0;
  localparam logic [2:0] S_STANDBY  = 3'd1;
  localparam logic [2:0] S_RUN      = 3'd2;
  localparam logic [2:0] S_BOOST    = 3'd3;
  localparam logic [2:0] S_CLEAN    = 3'd4;
  localparam logic [2:0] S_COOLDOWN = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic             used_q, used_d;
  logic             done_q, done_d;
  logic             pwr;
  logic             expire;
  logic             sel_ok;
  logic             sel_zero;

  assign expire   = tick_1hz && (cnt_q == CNT_W'(1));
  assign sel_zero = (level_sel == '0);
  assign sel_ok   = !sel_zero && (level_sel < LVL_W'(LEVELS));

`ifdef HOOD_GESTURE_EN
  // A pending swipe expires on the fifth tick after the first gesture.
  logic       gp_q, gp_d;
  logic [2:0] gw_q, gw_d;
  logic       first_g, second_g;

  always_comb begin
    first_g  = 1'b0;
    second_g = 1'b0;
    if (state_q == S_OFF) begin
      first_g  = gest_l;
      second_g = gest_r;
    end else if (state_q == S_RUN) begin
      first_g  = gest_r;
      second_g = gest_l;
    end
  end

  assign pwr          = power_pulse || (gp_q && second_g);
  assign gest_pending = gp_q;

  always_comb begin
    gp_d = gp_q;
    gw_d = gw_q;
    if (state_d != state_q) begin
      gp_d = 1'b0;
      gw_d = '0;
    end else if (gp_q) begin
      if (first_g) begin
        gp_d = 1'b0;
        gw_d = '0;
      end else if (tick_1hz) begin
        gp_d = (gw_q != 3'd1);
        gw_d = gw_q - 3'd1;
      end
    end else if (first_g) begin
      gp_d = 1'b1;
      gw_d = 3'd5;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gp_q <= 1'b0;
      gw_q <= '0;
    end else begin
      gp_q <= gp_d;
      gw_q <= gw_d;
    end
  end
`else
  assign pwr = power_pulse;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      lvl_q   <= '0;
      used_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      used_q  <= used_d;
      done_q  <= done_d;
    end
  end

  // Requests that a state ignores do not block lower-priority ones.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lvl_d   = lvl_q;
    used_d  = used_q;
    done_d  = 1'b0;
    case (state_q)
      S_OFF: begin
        cnt_d = '0;
        if (pwr) begin
          state_d = S_STANDBY;
          used_d  = 1'b0;
        end
      end
      S_STANDBY: begin
        if (pwr) begin
          state_d = S_OFF;
        end else if (boost_req && !used_q) begin
          state_d = S_BOOST;
          cnt_d   = CNT_W'(BOOST_SEC);
          used_d  = 1'b1;
        end else if (clean_req) begin
          state_d = S_CLEAN;
          cnt_d   = CNT_W'(CLEAN_SEC);
        end else if (level_req && sel_ok) begin
          state_d = S_RUN;
          lvl_d   = level_sel;
        end
      end
      S_RUN: begin
        if (pwr) begin
          state_d = S_COOLDOWN;
          cnt_d   = CNT_W'(OFF_DELAY_SEC);
        end else if (boost_req && !used_q) begin
          state_d = S_BOOST;
          cnt_d   = CNT_W'(BOOST_SEC);
          used_d  = 1'b1;
        end else if (level_req && sel_zero) begin
          state_d = S_STANDBY;
        end else if (level_req && sel_ok) begin
          lvl_d = level_sel;
        end
      end
      S_BOOST: begin
        if (pwr) begin
          state_d = S_COOLDOWN;
          cnt_d   = CNT_W'(OFF_DELAY_SEC);
        end else if (expire) begin
          state_d = S_RUN;
          lvl_d   = LVL_W'(LEVELS - 1);
          cnt_d   = '0;
        end else if (tick_1hz) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_CLEAN: begin
        if (pwr) begin
          state_d = S_OFF;
          cnt_d   = '0;
        end else if (expire) begin
          state_d = S_STANDBY;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else if (tick_1hz) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_COOLDOWN: begin
        if (pwr || expire) begin
          state_d = S_OFF;
          cnt_d   = '0;
        end else if (tick_1hz) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    fan_level  = '0;
    state_code = S_OFF;
    powered    = 1'b0;
    case (state_q)
      S_STANDBY, S_CLEAN: begin
        state_code = state_q;
        powered    = 1'b1;
      end
      S_RUN: begin
        state_code = state_q;
        powered    = 1'b1;
        fan_level  = lvl_q;
      end
      S_BOOST: begin
        state_code = state_q;
        powered    = 1'b1;
        fan_level  = LVL_W'(LEVELS);
      end
      S_COOLDOWN: begin
        state_code = state_q;
        powered    = 1'b1;
        fan_level  = LVL_W'(1);
      end
      default: ;
    endcase
  end

  assign countdown  = cnt_q;
  assign boost_used = used_q;
  assign clean_done = done_q;

endmodule

// File: tb/tb_hood_mode_fsm.sv
// Directed self-checking bench for hood_mode_fsm in its default build.
module tb_hood_mode_fsm;
  logic       clk = 1'b0;
  logic       reset;
  logic       tick_1hz;
  logic       power_pulse;
  logic       level_req;
  logic [1:0] level_sel;
  logic       boost_req;
  logic       clean_req;
  logic [1:0] fan_level;
  logic [2:0] state_code;
  logic [7:0] countdown;
  logic       powered;
  logic       boost_used;
  logic       clean_done;

  int total = 0;
  int bad = 0;
  int done_pulses = 0;
  int done_base;

  hood_mode_fsm dut (
    .clk         (clk),
    .reset       (reset),
    .tick_1hz    (tick_1hz),
    .power_pulse (power_pulse),
    .level_req   (level_req),
    .level_sel   (level_sel),
    .boost_req   (boost_req),
    .clean_req   (clean_req),
    .fan_level   (fan_level),
    .state_code  (state_code),
    .countdown   (countdown),
    .powered     (powered),
    .boost_used  (boost_used),
    .clean_done  (clean_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (clean_done === 1'b1) done_pulses++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input int st, input int fan, input int cnt);
    chk({tag, ".state"}, 32'(state_code), 32'(st));
    chk({tag, ".fan"}, 32'(fan_level), 32'(fan));
    chk({tag, ".cnt"}, 32'(countdown), 32'(cnt));
  endtask

  // Inputs are applied for one full clock (negedge to negedge).
  task automatic step(input logic pp, input logic lr, input logic [1:0] ls,
                      input logic br, input logic cr, input logic tk);
    power_pulse = pp; level_req = lr; level_sel = ls;
    boost_req = br; clean_req = cr; tick_1hz = tk;
    @(negedge clk);
    power_pulse = 1'b0; level_req = 1'b0; level_sel = 2'd0;
    boost_req = 1'b0; clean_req = 1'b0; tick_1hz = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 0, 2'd0, 0, 0, 1);
      step(0, 0, 2'd0, 0, 0, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; tick_1hz = 1'b0; power_pulse = 1'b0; level_req = 1'b0;
    level_sel = 2'd0; boost_req = 1'b0; clean_req = 1'b0;
    repeat (2) @(negedge clk);
    chk_st("rst", 0, 0, 0);
    chk("rst.powered", 32'(powered), 0);
    chk("rst.used", 32'(boost_used), 0);
    chk("rst.done", 32'(clean_done), 0);
    reset = 1'b0;

    step(0, 1, 2'd2, 1, 1, 1);
    chk_st("off_ignores", 0, 0, 0);
    step(1, 0, 2'd0, 0, 0, 0);
    chk_st("on", 1, 0, 0);
    chk("on.powered", 32'(powered), 1);
    step(0, 1, 2'd0, 0, 0, 0);
    chk_st("sb_sel0", 1, 0, 0);
    step(0, 1, 2'd3, 0, 0, 0);
    chk_st("sb_sel3", 1, 0, 0);
    step(0, 1, 2'd2, 0, 0, 0);
    chk_st("run2", 2, 2, 0);

    // boost request coincides with a tick that must not be counted
    step(0, 0, 2'd0, 1, 0, 1);
    chk_st("boost", 3, 3, 60);
    chk("boost.used", 32'(boost_used), 1);
    step(0, 1, 2'd1, 0, 1, 0);
    chk_st("boost_ign", 3, 3, 60);
    ticks(59);
    chk_st("boost59", 3, 3, 1);
    ticks(1);
    chk_st("boost_end", 2, 2, 0);
    chk("boost_end.used", 32'(boost_used), 1);
    step(0, 0, 2'd0, 1, 0, 0);
    chk_st("boost_again", 2, 2, 0);
    step(0, 0, 2'd0, 0, 1, 0);
    chk_st("run_clean_ign", 2, 2, 0);
    step(0, 1, 2'd1, 0, 0, 0);
    chk_st("run1", 2, 1, 0);

    step(1, 0, 2'd0, 0, 0, 0);
    chk_st("cool", 5, 1, 10);
    chk("cool.powered", 32'(powered), 1);
    ticks(9);
    chk_st("cool9", 5, 1, 1);
    ticks(1);
    chk_st("cool_end", 0, 0, 0);
    chk("cool_end.powered", 32'(powered), 0);

    step(1, 0, 2'd0, 0, 0, 0);
    chk("reon.used", 32'(boost_used), 0);
    done_base = done_pulses;
    step(0, 0, 2'd0, 0, 1, 0);
    chk_st("clean", 4, 0, 180);
    ticks(179);
    chk_st("clean179", 4, 0, 1);
    chk("clean179.done", 32'(done_pulses - done_base), 0);
    step(0, 0, 2'd0, 0, 0, 1);
    chk_st("clean_end", 1, 0, 0);
    chk("clean_end.done", 32'(clean_done), 1);
    step(0, 0, 2'd0, 0, 0, 0);
    chk("clean_end.done_low", 32'(clean_done), 0);
    chk("clean_end.pulses", 32'(done_pulses - done_base), 1);

    done_base = done_pulses;
    step(0, 0, 2'd0, 0, 1, 0);
    ticks(49);
    chk_st("clean49", 4, 0, 131);
    step(1, 0, 2'd0, 0, 0, 1);
    chk_st("clean_abort", 0, 0, 0);
    step(0, 0, 2'd0, 0, 0, 0);
    chk("clean_abort.pulses", 32'(done_pulses - done_base), 0);

    step(1, 0, 2'd0, 0, 0, 0);
    step(0, 1, 2'd1, 0, 0, 0);
    step(1, 0, 2'd0, 0, 0, 0);
    ticks(4);
    chk_st("cool4", 5, 1, 6);
    step(1, 0, 2'd0, 0, 0, 0);
    chk_st("cool_abort", 0, 0, 0);

    step(1, 0, 2'd0, 0, 0, 0);
    step(1, 1, 2'd2, 1, 0, 0);
    chk_st("prio_sb", 0, 0, 0);
    chk("prio_sb.used", 32'(boost_used), 0);

    step(1, 0, 2'd0, 0, 0, 0);
    step(0, 1, 2'd2, 0, 0, 0);
    step(0, 0, 2'd0, 0, 0, 0);
    chk_st("run_to_sb_pre", 2, 2, 0);
    step(0, 1, 2'd0, 0, 0, 0);
    chk_st("run_sel0", 1, 0, 0);
    step(0, 1, 2'd2, 0, 0, 0);
    step(0, 1, 2'd1, 1, 0, 0);
    chk_st("prio_run", 3, 3, 60);

    ticks(23);
    chk_st("boost23", 3, 3, 37);
    #2 reset = 1'b1;
    #1;
    chk_st("async_rst", 0, 0, 0);
    chk("async_rst.used", 32'(boost_used), 0);
    chk("async_rst.powered", 32'(powered), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    ticks(3);
    chk_st("post_rst", 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
